axilite_csr_write_ctrl: RTL and testbench



---
 rtl/axilite_pkg.sv | 19 +
 rtl/axilite_csr_write_ctrl.sv | 106 ++++++++++
 tb/tb_axilite_csr_write_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/axilite_pkg.sv
// Shared AXI-lite definitions: B-channel response codes, the 2-bit response
// type and the write-controller state encoding.
package axilite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'd0;
    localparam resp_t RESP_EXOKAY = 2'd1;
    localparam resp_t RESP_SLVERR = 2'd2;
    localparam resp_t RESP_DECERR = 2'd3;

    // 2'd3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_HELD = 2'd1,
        RESP      = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axilite_csr_write_ctrl.sv
// AXI-lite write-channel controller: accepts AW, holds the address toward the
// CSR data stage, collects its response pulse (or times out with SLVERR) and
// drives the B channel until bready. One outstanding write at a time.
module axilite_csr_write_ctrl
    import axilite_pkg::*;
#(
    parameter int unsigned ADDR_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter resp_t       RESP_OKAY      = axilite_pkg::RESP_OKAY,
    parameter resp_t       RESP_EXOKAY    = axilite_pkg::RESP_EXOKAY,
    parameter resp_t       RESP_SLVERR    = axilite_pkg::RESP_SLVERR,
    parameter resp_t       RESP_DECERR    = axilite_pkg::RESP_DECERR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] awaddr,
    input  logic                 awvalid,
    output logic                 awready,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 addr_good,
    input  logic [1:0]           resp_in,
    input  logic                 resp_valid_in,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    // A zero timeout keeps a 1-bit counter that is never advanced.
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    wr_state_t       state;
    logic [TO_W-1:0] to_cnt;

    // Single registered FSM: AW accept, response/timeout collection, B handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            awready   <= 1'b0;
            addr      <= '0;
            addr_good <= 1'b0;
            bresp     <= RESP_OKAY;
            bvalid    <= 1'b0;
            wr_count  <= '0;
            err_count <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid && awready) begin
                        addr      <= awaddr;
                        addr_good <= 1'b1;
                        awready   <= 1'b0;
                        to_cnt    <= '0;
                        state     <= ADDR_HELD;
                    end else begin
                        // Raises awready the first cycle after reset or recovery.
                        awready <= 1'b1;
                    end
                end

                ADDR_HELD: begin
                    // The data-stage response takes priority over a coincident timeout.
                    if (resp_valid_in) begin
                        bresp     <= resp_in;
                        bvalid    <= 1'b1;
                        addr_good <= 1'b0;
                        state     <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (to_cnt == TO_W'(TO_LAST)) begin
                            bresp     <= RESP_SLVERR;
                            bvalid    <= 1'b1;
                            addr_good <= 1'b0;
                            state     <= RESP;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end

                RESP: begin
                    if (bvalid && bready) begin
                        bvalid   <= 1'b0;
                        wr_count <= wr_count + CNT_WIDTH'(1);
                        if (bresp != RESP_OKAY) begin
                            err_count <= err_count + CNT_WIDTH'(1);
                        end
                        awready <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    awready   <= 1'b0;
                    bvalid    <= 1'b0;
                    addr_good <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_csr_write_ctrl.sv
// Directed bench for axilite_csr_write_ctrl with a 4-cycle W-data timeout.
module tb_axilite_csr_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] addr;
    logic        addr_good;
    logic [1:0]  resp_in;
    logic        resp_valid_in;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] wr_count;
    logic [15:0] err_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    axilite_csr_write_ctrl #(
        .ADDR_SIZE(32),
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .awaddr(awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .addr(addr),
        .addr_good(addr_good),
        .resp_in(resp_in),
        .resp_valid_in(resp_valid_in),
        .bresp(bresp),
        .bvalid(bvalid),
        .bready(bready),
        .wr_count(wr_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; awaddr = '0; awvalid = 1'b0; resp_in = '0;
        resp_valid_in = 1'b0; bready = 1'b0;
        tick(); tick();
        check("rst_awready", awready, 0);
        check("rst_addr", addr, 0);
        check("rst_addr_good", addr_good, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_wr", wr_count, 0);
        check("rst_err", err_count, 0);

        // awready rises one cycle after reset release
        rst = 1'b0;
        tick();
        check("post_rst_awready", awready, 1);

        // Basic write with OKAY response two cycles after accept
        awaddr = 32'h8; awvalid = 1'b1; bready = 1'b1;
        tick();
        check("basic_awready", awready, 0);
        check("basic_addr", addr, 32'h8);
        check("basic_addr_good", addr_good, 1);
        awvalid = 1'b0;
        tick();
        check("basic_no_b_yet", bvalid, 0);
        resp_valid_in = 1'b1; resp_in = 2'd0;
        tick();
        check("basic_bvalid", bvalid, 1);
        check("basic_bresp", bresp, 0);
        check("basic_addr_good_drop", addr_good, 0);
        resp_valid_in = 1'b0;
        tick();
        check("basic_b_done", bvalid, 0);
        check("basic_wr", wr_count, 1);
        check("basic_err", err_count, 0);
        check("basic_awready_back", awready, 1);

        // Back-pressure: EXOKAY held 10 cycles, awvalid held high throughout
        bready = 1'b0; awaddr = 32'h10; awvalid = 1'b1;
        tick();
        check("bp_addr", addr, 32'h10);
        awaddr = 32'h20;
        resp_valid_in = 1'b1; resp_in = 2'd1;
        tick();
        check("bp_bvalid", bvalid, 1);
        check("bp_addr_stable", addr, 32'h10);
        resp_valid_in = 1'b0; resp_in = 2'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_bvalid", bvalid, 1);
            check("bp_hold_bresp", bresp, 1);
            check("bp_hold_awready", awready, 0);
            check("bp_hold_addr_good", addr_good, 0);
        end
        bready = 1'b1;
        tick();
        check("bp_b_done", bvalid, 0);
        check("bp_awready", awready, 1);
        check("bp_wr", wr_count, 2);
        check("bp_err_exokay", err_count, 1);
        tick();
        check("bp_next_accept_awready", awready, 0);
        check("bp_next_addr", addr, 32'h20);
        check("bp_next_addr_good", addr_good, 1);
        awvalid = 1'b0;

        // Error response from the data stage
        resp_valid_in = 1'b1; resp_in = 2'd2;
        tick();
        check("err_bvalid", bvalid, 1);
        check("err_bresp", bresp, 2);
        resp_valid_in = 1'b0;
        tick();
        check("err_wr", wr_count, 3);
        check("err_err", err_count, 2);

        // Timeout: no response, SLVERR exactly 4 cycles after addr_good rises
        bready = 1'b0; awaddr = 32'h30; awvalid = 1'b1;
        tick();
        check("to_addr_good", addr_good, 1);
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait_bvalid", bvalid, 0);
            check("to_wait_addr_good", addr_good, 1);
        end
        tick();
        check("to_bvalid", bvalid, 1);
        check("to_bresp", bresp, 2);
        check("to_addr_good_drop", addr_good, 0);
        bready = 1'b1;
        tick();
        check("to_wr", wr_count, 4);
        check("to_err", err_count, 3);

        // Response pulse in IDLE is ignored
        resp_valid_in = 1'b1; resp_in = 2'd3;
        tick();
        check("idle_resp_bvalid", bvalid, 0);
        check("idle_resp_wr", wr_count, 4);
        check("idle_resp_err", err_count, 3);
        check("idle_resp_awready", awready, 1);
        resp_valid_in = 1'b0;

        // Same-cycle tie: OKAY response on the timeout cycle wins
        awaddr = 32'h40; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick(); tick(); tick();
        check("tie_pre_bvalid", bvalid, 0);
        resp_valid_in = 1'b1; resp_in = 2'd0;
        tick();
        check("tie_bvalid", bvalid, 1);
        check("tie_bresp", bresp, 0);
        resp_valid_in = 1'b0;
        tick();
        check("tie_wr", wr_count, 5);
        check("tie_err", err_count, 3);

        // Reset while a B response is pending
        bready = 1'b0; awaddr = 32'h50; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        resp_valid_in = 1'b1; resp_in = 2'd2;
        tick();
        resp_valid_in = 1'b0;
        check("mid_bvalid", bvalid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_addr_good", addr_good, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_wr", wr_count, 0);
        check("mid_rst_err", err_count, 0);
        rst = 1'b0;
        tick();
        check("mid_rel_awready", awready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
